// File: rtl/hex_disp_pkg.sv
// Shared types and constants for the seven-segment scroll/blink display controller.
package hex_disp_pkg;

  localparam int MAX_NIBBLES = 16;
  localparam int DIGITS      = 8;

  // All segments off (active-low).
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Active-low {g,f,e,d,c,b,a} patterns, indexed by nibble value.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  // Load-port mode encodings; 2'b11 falls back to static.
  localparam logic [1:0] MODE_STATIC = 2'b00;
  localparam logic [1:0] MODE_SCROLL = 2'b01;
  localparam logic [1:0] MODE_BLINK  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STATIC = 2'd1,
    ST_SCROLL = 2'd2,
    ST_BLINK  = 2'd3
  } hex_state_t;

  // Message lengths above the nibble capacity are clamped to the capacity.
  function automatic logic [4:0] clamp_len(input logic [4:0] len);
    return (len > 5'(MAX_NIBBLES)) ? 5'(MAX_NIBBLES) : len;
  endfunction

endpackage

// File: rtl/hex7seg.sv
// Combinational hex nibble to active-low seven-segment decoder.
module hex7seg
  import hex_disp_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);

  assign o_seg = SEG_TABLE[i_nib];

endmodule

// File: rtl/hex_scroll_ctrl.sv
// Eight-digit hex display controller: static, scroll-left and blink modes
// paced by a tick divider, fed through a valid/ready message load port.
//
// Handshake: a message transfers on any cycle where load_valid && load_ready
// at the rising clock edge; the producer holds load_valid and the load_* data
// stable until that edge. load_ready depends only on the current state and
// scroll offset, never on load_valid.
module hex_scroll_ctrl
  import hex_disp_pkg::*;
#(
  parameter int TICK_DIV = 12_500_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [63:0] load_data,
  input  logic [4:0]  load_len,
  input  logic [1:0]  load_mode,
  input  logic        pause,
  output logic        wrap_pulse,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3,
  output logic [6:0]  HEX4,
  output logic [6:0]  HEX5,
  output logic [6:0]  HEX6,
  output logic [6:0]  HEX7,
  output logic [1:0]  dbg_state
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);

  hex_state_t    r_state;
  hex_state_t    w_state_nxt;
  logic [63:0]   r_data;
  logic [4:0]    r_len;
  logic [CW-1:0] r_cnt;
  logic [4:0]    r_off;
  logic          r_phase;
  logic          r_wrap_pre;
  logic          r_wrap;
  logic [6:0]    r_hex [DIGITS];

  logic          w_ready;
  logic          w_accept;
  logic          w_tick;
  logic [4:0]    w_len_clamped;
  logic [4:0]    w_period;
  logic [4:0]    w_last_off;
  logic [5:0]    w_idx;
  logic [3:0]    w_pos;
  logic [3:0]    w_nib   [DIGITS];
  logic          w_blank [DIGITS];
  logic [6:0]    w_seg   [DIGITS];
  logic [6:0]    w_disp  [DIGITS];

  assign w_len_clamped = clamp_len(load_len);
  assign w_period      = r_len + 5'd8;
  assign w_last_off    = r_len + 5'd7;
  assign w_tick        = !pause && (r_cnt == TICK_LAST);

  // State register; reset overrides any pending load.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state and load_ready: scroll refuses loads except at offset 0.
  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b1;
    if (r_state == ST_SCROLL && r_off != 5'd0) w_ready = 1'b0;
    w_accept = load_valid && w_ready;
    if (w_accept) begin
      if (w_len_clamped == 5'd0) begin
        w_state_nxt = ST_IDLE;
      end else begin
        case (load_mode)
          MODE_SCROLL: w_state_nxt = ST_SCROLL;
          MODE_BLINK:  w_state_nxt = ST_BLINK;
          default:     w_state_nxt = ST_STATIC;
        endcase
      end
    end
  end

  // Message latch, tick divider, scroll offset, blink phase and wrap pulse.
  // A load restarts all timing and discards a coincident tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data     <= 64'd0;
      r_len      <= 5'd0;
      r_cnt      <= '0;
      r_off      <= 5'd0;
      r_phase    <= 1'b1;
      r_wrap_pre <= 1'b0;
      r_wrap     <= 1'b0;
    end else begin
      // Delay one cycle so the pulse lines up with the HEX frame showing offset 0.
      r_wrap     <= r_wrap_pre;
      r_wrap_pre <= 1'b0;
      if (w_accept) begin
        r_data  <= load_data;
        r_len   <= w_len_clamped;
        r_cnt   <= '0;
        r_off   <= 5'd0;
        r_phase <= 1'b1;
      end else begin
        if (!pause) r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
        if (w_tick && r_state == ST_SCROLL) begin
          if (r_off == w_last_off) begin
            r_off      <= 5'd0;
            r_wrap_pre <= 1'b1;
          end else begin
            r_off <= r_off + 5'd1;
          end
        end
        if (w_tick && r_state == ST_BLINK) r_phase <= ~r_phase;
      end
    end
  end

  // Per-digit nibble selection and blanking for the current mode.
  always_comb begin
    for (int i = 0; i < DIGITS; i++) begin
      w_nib[i]   = 4'h0;
      w_blank[i] = 1'b1;
    end
    w_idx = 6'd0;
    w_pos = 4'd0;
    case (r_state)
      ST_STATIC, ST_BLINK: begin
        if (r_state == ST_STATIC || r_phase) begin
          for (int i = 0; i < DIGITS; i++) begin
            if (5'(i) < r_len) begin
              w_nib[i]   = r_data[4*i +: 4];
              w_blank[i] = 1'b0;
            end
          end
        end
      end
      ST_SCROLL: begin
        // Leftmost digit shows sequence position o; the sequence is the
        // message most-significant nibble first, followed by 8 blanks.
        for (int j = 0; j < DIGITS; j++) begin
          w_idx = {1'b0, r_off} + 6'(j);
          if (w_idx >= {1'b0, w_period}) w_idx = w_idx - {1'b0, w_period};
          if (w_idx < {1'b0, r_len}) begin
            w_pos = 4'(r_len - 5'd1 - w_idx[4:0]);
            w_nib[DIGITS-1-j]   = r_data[{w_pos, 2'b00} +: 4];
            w_blank[DIGITS-1-j] = 1'b0;
          end
        end
      end
      default: ;
    endcase
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    hex7seg u_dec (
      .i_nib (w_nib[g]),
      .o_seg (w_seg[g])
    );
    assign w_disp[g] = w_blank[g] ? SEG_BLANK : w_seg[g];
  end

  // Registered segment outputs; reset blanks the display on the next edge.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DIGITS; i++) begin
      if (rst) r_hex[i] <= SEG_BLANK;
      else     r_hex[i] <= w_disp[i];
    end
  end

  assign load_ready = w_ready;
  assign wrap_pulse = r_wrap;
  assign dbg_state  = r_state;
  assign HEX0 = r_hex[0];
  assign HEX1 = r_hex[1];
  assign HEX2 = r_hex[2];
  assign HEX3 = r_hex[3];
  assign HEX4 = r_hex[4];
  assign HEX5 = r_hex[5];
  assign HEX6 = r_hex[6];
  assign HEX7 = r_hex[7];

endmodule
